// File: rtl/onehot_dec_pkg.sv
// Purpose: shared types and defaults for the one-hot decoder/sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: state_e (IDLE/HOLD/SCAN) and the default select width.
package onehot_dec_pkg;

   localparam int ONEHOT_DEC_N_DEF = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      SCAN = 2'd2
   } state_e;

endpackage

// File: rtl/onehot_dec_comb.sv
// Purpose: combinational N -> 2**N one-hot decode.
// Latency: zero (pure combinational).
// Backpressure: none.
// Ports: sel [N-1:0] select in; dec [2**N-1:0] one-hot out, bit sel set.
module onehot_dec_comb #(
   parameter int N = 3
) (
   input  logic [N-1:0]    sel,
   output logic [2**N-1:0] dec
);

   always_comb begin
      dec      = '0;
      dec[sel] = 1'b1;
   end

endmodule

// File: rtl/onehot_dec_seq.sv
// Purpose: registered one-hot decoder with optional walking-one scan
//          (scan mode present only when ONEHOT_DEC_SCAN_EN is defined).
// Latency: one cycle from a capturing edge to y/idx/valid.
// Backpressure: none; en low freezes all state.
// Ports: clk, rst_n (async active-low), en, clr, load, x[N-1:0], scan, dir
//        in; y[2**N-1:0] one-hot, idx[N-1:0], valid out.
module onehot_dec_seq
   import onehot_dec_pkg::*;
#(
   parameter int N       = ONEHOT_DEC_N_DEF,
   parameter int RST_IDX = 0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            en,
   input  logic            clr,
   input  logic            load,
   input  logic [N-1:0]    x,
   input  logic            scan,
   input  logic            dir,
   output logic [2**N-1:0] y,
   output logic [N-1:0]    idx,
   output logic            valid
);

   localparam int W = 2**N;

   state_e         state_q, state_d;
   logic [N-1:0]   idx_q, idx_d;
   logic           valid_q, valid_d;
   logic [W-1:0]   y_q, y_d;
   logic [W-1:0]   dec_y;

`ifdef ONEHOT_DEC_SCAN_EN
   localparam logic [N-1:0] IDX_START = N'(RST_IDX);
   localparam logic [N-1:0] IDX_ONE   = N'(1);
`else
   // scan/dir stay on the port list but have no function in this build.
   logic unused_scan_dir;
   assign unused_scan_dir = scan ^ dir;
`endif

   // Next state / index / valid. Priority: clr > load > scan > hold.
   // clr leaves idx untouched; only valid drops.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      valid_d = valid_q;
      if (en) begin
         if (clr) begin
            state_d = IDLE;
            valid_d = 1'b0;
         end else if (load) begin
            state_d = HOLD;
            idx_d   = x;
            valid_d = 1'b1;
         end
`ifdef ONEHOT_DEC_SCAN_EN
         else begin
            case (state_q)
               IDLE: if (scan) begin
                  state_d = SCAN;
                  idx_d   = IDX_START;
                  valid_d = 1'b1;
               end
               HOLD: if (scan) begin
                  state_d = SCAN;
                  valid_d = 1'b1;
               end
               SCAN: begin
                  // Natural N-bit wrap gives modulo-2**N stepping both ways.
                  if (scan) idx_d = dir ? (idx_q - IDX_ONE) : (idx_q + IDX_ONE);
                  else      state_d = HOLD;
               end
               default: begin
                  state_d = IDLE;
                  valid_d = 1'b0;
               end
            endcase
         end
`endif
      end
   end

   // y is always derived from the next idx/valid pair, so y == onehot(idx)
   // while valid and zero otherwise, including across en=0 freezes.
   onehot_dec_comb #(.N(N)) u_dec (
      .sel (idx_d),
      .dec (dec_y)
   );

   assign y_d = valid_d ? dec_y : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         valid_q <= 1'b0;
         y_q     <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
         y_q     <= y_d;
      end
   end

   assign y     = y_q;
   assign idx   = idx_q;
   assign valid = valid_q;

endmodule
